fetch_exec_unit: RTL and testbench

Downstream consumer of the combinational program ROM. Drives the ROM line address (PC) and latches the returned 8-bit instruction. Decodes and executes it against a 4 x 8-bit register file with zero/carry flags. Two-cycle FETCH/EXECUTE sequencer with run/stall control, halt detection and a debug register read port.

---
 rtl/fetch_exec_unit.sv | 127 ++++++++++++
 tb/tb_fetch_exec_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_unit.sv
// Two-cycle FETCH/EXECUTE core: drives the ROM address, latches the returned
// instruction and executes it against a 4 x REG_W register file with Z/C flags.
module fetch_exec_unit #(
  parameter int unsigned PROG_LEN = 6,
  parameter int unsigned REG_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [7:0]       instr,
  output logic [7:0]       pc,
  input  logic [1:0]       dbg_sel,
  output logic [REG_W-1:0] dbg_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             retire,
  output logic             halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_pc, w_pc_nxt;
  logic [7:0]       r_ir, w_ir_nxt;
  logic [REG_W-1:0] r_regs [4];
  logic             r_z, w_z_nxt;
  logic             r_c, w_c_nxt;

  logic [3:0]       w_op;
  logic [1:0]       w_rd, w_rs;
  logic [REG_W-1:0] w_a, w_b, w_res;
  logic [REG_W:0]   w_sum, w_diff;
  logic             w_we;

  assign w_op = r_ir[7:4];
  assign w_rd = r_ir[3:2];
  assign w_rs = r_ir[1:0];

  // Both operands come from the registered file, so rd==rs sees the pre-write value.
  assign w_a    = r_regs[w_rd];
  assign w_b    = r_regs[w_rs];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    w_we        = 1'b0;
    w_res       = '0;
    unique case (r_state)
      S_FETCH: begin
        if (run) begin
          w_ir_nxt    = instr;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_op)
          OP_MOV: begin
            w_we  = 1'b1;
            w_res = {{(REG_W-2){1'b0}}, w_rs};
          end
          OP_ADD: begin
            w_we    = 1'b1;
            w_res   = w_sum[REG_W-1:0];
            w_c_nxt = w_sum[REG_W];
          end
          OP_SUB: begin
            w_we    = 1'b1;
            w_res   = w_diff[REG_W-1:0];
            w_c_nxt = w_diff[REG_W];
          end
          OP_NOT: begin
            w_we  = 1'b1;
            w_res = ~w_a;
          end
          default: ;
        endcase
        if (w_we) w_z_nxt = (w_res == '0);
        if (w_op == OP_HALT || r_pc == LAST_PC) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: ;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_z     <= w_z_nxt;
      r_c     <= w_c_nxt;
      if (w_we) r_regs[w_rd] <= w_res;
    end
  end

  assign pc       = r_pc;
  assign dbg_data = r_regs[dbg_sel];
  assign flag_z   = r_z;
  assign flag_c   = r_c;
  assign retire   = (r_state == S_EXEC);
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_exec_unit.sv
// Directed bench: three core instances (PROG_LEN 6, 3, 256) fed by bench-side ROM arrays.
module tb_fetch_exec_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // PROG_LEN=6 instance
  logic [7:0] rom6 [256];
  logic       rst6, run6;
  logic [1:0] dbg_sel6;
  logic [7:0] pc6, dbg6, instr6;
  logic       z6, c6, retire6, halted6;
  assign instr6 = rom6[pc6];

  fetch_exec_unit #(.PROG_LEN(6), .REG_W(8)) u_dut6 (
    .clk(clk), .rst(rst6), .run(run6), .instr(instr6), .pc(pc6),
    .dbg_sel(dbg_sel6), .dbg_data(dbg6), .flag_z(z6), .flag_c(c6),
    .retire(retire6), .halted(halted6)
  );

  // PROG_LEN=3 instance
  logic [7:0] rom3 [256];
  logic       rst3, run3;
  logic [1:0] dbg_sel3;
  logic [7:0] pc3, dbg3, instr3;
  logic       z3, c3, retire3, halted3;
  assign instr3 = rom3[pc3];

  fetch_exec_unit #(.PROG_LEN(3), .REG_W(8)) u_dut3 (
    .clk(clk), .rst(rst3), .run(run3), .instr(instr3), .pc(pc3),
    .dbg_sel(dbg_sel3), .dbg_data(dbg3), .flag_z(z3), .flag_c(c3),
    .retire(retire3), .halted(halted3)
  );

  // PROG_LEN=256 instance running an all-NOP program
  logic       rst256, run256;
  logic [1:0] dbg_sel256;
  logic [7:0] pc256, dbg256, instr256;
  logic       z256, c256, retire256, halted256;

  fetch_exec_unit #(.PROG_LEN(256), .REG_W(8)) u_dut256 (
    .clk(clk), .rst(rst256), .run(run256), .instr(instr256), .pc(pc256),
    .dbg_sel(dbg_sel256), .dbg_data(dbg256), .flag_z(z256), .flag_c(c256),
    .retire(retire256), .halted(halted256)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic regs6(input string tag, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      dbg_sel6 = 2'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), {24'd0, dbg6}, {24'd0, exp[i]});
    end
  endtask

  task automatic reg3(input string tag, input logic [1:0] s, input logic [7:0] e);
    dbg_sel3 = s;
    #1;
    chk(tag, {24'd0, dbg3}, {24'd0, e});
  endtask

  // Runs the 6-line core until halted or the budget expires.
  task automatic run6_to_halt(input int budget, output int cyc, output int nret);
    cyc = 0; nret = 0;
    while (!halted6 && cyc < budget) begin
      step(1);
      cyc++;
      if (retire6) nret++;
    end
  endtask

  task automatic run3_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted3 && cyc < budget) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic load_prog1;
    for (int i = 0; i < 256; i++) rom6[i] = 8'h00;
    rom6[0] = 8'h8F; // MOV R3,3
    rom6[1] = 8'h8A; // MOV R2,2
    rom6[2] = 8'h85; // MOV R1,1
    rom6[3] = 8'h1E; // ADD R3,R2
    rom6[4] = 8'h29; // SUB R2,R1
    rom6[5] = 8'h34; // NOT R1
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, nret, c2, r2;
    load_prog1();
    for (int i = 0; i < 256; i++) rom3[i] = 8'h00;
    rst6 = 1'b1; run6 = 1'b1; dbg_sel6 = 2'd3;
    rst3 = 1'b1; run3 = 1'b0; dbg_sel3 = 2'd0;
    rst256 = 1'b1; run256 = 1'b0; dbg_sel256 = 2'd0; instr256 = 8'h00;

    // Scenario 1: reset state, then the 6-line program
    step(2);
    chk("rst pc", {24'd0, pc6}, 32'd0);
    chk("rst retire", {31'd0, retire6}, 32'd0);
    chk("rst halted", {31'd0, halted6}, 32'd0);
    chk("rst z", {31'd0, z6}, 32'd0);
    chk("rst c", {31'd0, c6}, 32'd0);
    regs6("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    dbg_sel6 = 2'd3;
    rst6 = 1'b0;
    step(1);
    chk("s1 retire first exec", {31'd0, retire6}, 32'd1);
    chk("s1 dbg old value during write", {24'd0, dbg6}, 32'h00);
    step(1);
    chk("s1 dbg new value after edge", {24'd0, dbg6}, 32'h03);
    chk("s1 pc after line0", {24'd0, pc6}, 32'd1);
    run6_to_halt(40, c2, r2);
    cyc = 2 + c2; nret = 1 + r2;
    chk("s1 halt cycles", cyc, 32'd12);
    chk("s1 retire pulses", nret, 32'd6);
    chk("s1 pc", {24'd0, pc6}, 32'd5);
    chk("s1 z", {31'd0, z6}, 32'd0);
    chk("s1 c", {31'd0, c6}, 32'd0);
    regs6("s1", 8'h00, 8'hFE, 8'h01, 8'h05);
    step(3);
    chk("s1 frozen halted", {31'd0, halted6}, 32'd1);
    chk("s1 frozen retire", {31'd0, retire6}, 32'd0);
    chk("s1 frozen pc", {24'd0, pc6}, 32'd5);

    // Scenario 4: stall 5 cycles in FETCH at line 2
    rst6 = 1'b1;
    step(1);
    rst6 = 1'b0;
    step(4);
    chk("s4 pc before stall", {24'd0, pc6}, 32'd2);
    run6 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("s4 stall retire %0d", i), {31'd0, retire6}, 32'd0);
      chk($sformatf("s4 stall pc %0d", i), {24'd0, pc6}, 32'd2);
    end
    regs6("s4 stalled", 8'h00, 8'h00, 8'h02, 8'h03);
    run6 = 1'b1;
    run6_to_halt(40, c2, r2);
    chk("s4 halt cycles", 4 + 5 + c2, 32'd17);
    chk("s4 pc", {24'd0, pc6}, 32'd5);
    chk("s4 z", {31'd0, z6}, 32'd0);
    chk("s4 c", {31'd0, c6}, 32'd0);
    regs6("s4", 8'h00, 8'hFE, 8'h01, 8'h05);

    // Scenario 5: HALT opcode at line 1
    rst6 = 1'b1;
    rom6[1] = 8'hF0;
    step(1);
    rst6 = 1'b0;
    run6_to_halt(40, c2, r2);
    chk("s5 halt cycles", c2, 32'd4);
    chk("s5 retire pulses", r2, 32'd2);
    chk("s5 pc", {24'd0, pc6}, 32'd1);
    chk("s5 z", {31'd0, z6}, 32'd0);
    regs6("s5", 8'h00, 8'h00, 8'h00, 8'h03);

    // Scenario 6: reset in the EXECUTE cycle of ADD R3,R2
    load_prog1();
    rst6 = 1'b1;
    step(1);
    rst6 = 1'b0;
    step(7);
    chk("s6 in add exec", {31'd0, retire6}, 32'd1);
    chk("s6 add pc", {24'd0, pc6}, 32'd3);
    rst6 = 1'b1;
    step(1);
    chk("s6 rst pc", {24'd0, pc6}, 32'd0);
    chk("s6 rst retire", {31'd0, retire6}, 32'd0);
    chk("s6 rst halted", {31'd0, halted6}, 32'd0);
    chk("s6 rst z", {31'd0, z6}, 32'd0);
    chk("s6 rst c", {31'd0, c6}, 32'd0);
    regs6("s6 rst", 8'h00, 8'h00, 8'h00, 8'h00);
    rst6 = 1'b0;
    run6_to_halt(40, c2, r2);
    chk("s6 halt cycles", c2, 32'd12);
    chk("s6 pc", {24'd0, pc6}, 32'd5);
    regs6("s6", 8'h00, 8'hFE, 8'h01, 8'h05);

    // Scenario 2: SUB with borrow
    rom3[0] = 8'h81; rom3[1] = 8'h86; rom3[2] = 8'h21;
    run3 = 1'b1;
    step(1);
    rst3 = 1'b0;
    run3_to_halt(20, cyc);
    chk("s2 halt cycles", cyc, 32'd6);
    chk("s2 pc", {24'd0, pc3}, 32'd2);
    chk("s2 z", {31'd0, z3}, 32'd0);
    chk("s2 c", {31'd0, c3}, 32'd1);
    reg3("s2 R0", 2'd0, 8'hFF);
    reg3("s2 R1", 2'd1, 8'h02);

    // Scenario 3: ADD wraps to zero with carry
    rst3 = 1'b1;
    rom3[0] = 8'h30; rom3[1] = 8'h85; rom3[2] = 8'h11;
    step(1);
    rst3 = 1'b0;
    run3_to_halt(20, cyc);
    chk("s3 halt cycles", cyc, 32'd6);
    chk("s3 z", {31'd0, z3}, 32'd1);
    chk("s3 c", {31'd0, c3}, 32'd1);
    reg3("s3 R0", 2'd0, 8'h00);
    rst3 = 1'b1;
    step(1);
    chk("s3 rst z", {31'd0, z3}, 32'd0);
    chk("s3 rst c", {31'd0, c3}, 32'd0);

    // rd==rs: MOV R2,3 / ADD R2,R2 / SUB R2,R2
    rom3[0] = 8'h8B; rom3[1] = 8'h1A; rom3[2] = 8'h2A;
    rst3 = 1'b0;
    step(4);
    reg3("dup add R2", 2'd2, 8'h06);
    chk("dup add c", {31'd0, c3}, 32'd0);
    run3_to_halt(20, cyc);
    reg3("dup sub R2", 2'd2, 8'h00);
    chk("dup sub z", {31'd0, z3}, 32'd1);
    chk("dup sub c", {31'd0, c3}, 32'd0);

    // PROG_LEN=256: line 255 halts without wrapping
    run256 = 1'b1;
    step(1);
    rst256 = 1'b0;
    cyc = 0;
    while (!halted256 && cyc < 600) begin
      step(1);
      cyc++;
    end
    chk("p256 halt cycles", cyc, 32'd512);
    chk("p256 pc", {24'd0, pc256}, 32'd255);
    chk("p256 dbg R0", {24'd0, dbg256}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
